adda_clk_rst_seq: RTL and testbench

Reset sequencer directly downstream of the ADDA PLL wrapper: consumes the PLL lock indication and produces the ordered reset releases for the ADC and DAC clock domains. It holds both converter datapaths in reset until lock has been stable for a programmable interval, and drives a PLL reset request with timeout/retry. On lock loss it re-asserts converter resets and re-runs the sequence. It runs on the free-running 50 MHz init clock, not on a PLL output.

---
 rtl/adda_pkg.sv | 25 ++
 rtl/adda_sync_2ff.sv | 22 ++
 rtl/adda_clk_rst_seq.sv | 124 ++++++++++++
 tb/tb_adda_clk_rst_seq.sv | 278 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/adda_pkg.sv
// ADDA shared types and default constants.
// Used by the ADDA top and its reset sequencer.
package adda_pkg;

  typedef enum logic [2:0] {
    PLL_RST,
    WAIT_LOCK,
    STABLE,
    REL_ADC,
    RUN,
    FAULT
  } adda_seq_state_t;

  localparam int unsigned ADDA_LOCK_STABLE_CYC  = 1024;
  localparam int unsigned ADDA_LOCK_TIMEOUT_CYC = 50000;
  localparam int unsigned ADDA_RST_PULSE_CYC    = 16;
  localparam int unsigned ADDA_STAGGER_CYC      = 8;
  localparam int unsigned ADDA_MAX_RETRY        = 3;

  // counter width that stays legal for tiny parameter values
  function automatic int unsigned cw(int unsigned n);
    return (n < 2) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/adda_sync_2ff.sv
// Two-flop synchronizer for a single async level.
// Async active-low reset, resets to 0.
module adda_sync_2ff (
  input  logic clk,
  input  logic rst_n,
  input  logic d,
  output logic q
);

  logic meta;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      meta <= 1'b0;
      q    <= 1'b0;
    end else begin
      meta <= d;
      q    <= meta;
    end
  end

endmodule

// File: rtl/adda_clk_rst_seq.sv
// ADDA reset sequencer: PLL reset/retry, lock qualification,
// staggered ADC/DAC reset release, lock-loss recovery.
module adda_clk_rst_seq
  import adda_pkg::*;
#(
  parameter int unsigned LOCK_STABLE_CYC  = ADDA_LOCK_STABLE_CYC,
  parameter int unsigned LOCK_TIMEOUT_CYC = ADDA_LOCK_TIMEOUT_CYC,
  parameter int unsigned RST_PULSE_CYC    = ADDA_RST_PULSE_CYC,
  parameter int unsigned STAGGER_CYC      = ADDA_STAGGER_CYC,
  parameter int unsigned MAX_RETRY        = ADDA_MAX_RETRY
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       pll_lock,
  input  logic       retry_i,
  output logic       pll_rst_req,
  output logic       adc_rst_n,
  output logic       dac_rst_n,
  output logic       ready,
  output logic       fault,
  output logic [7:0] lock_loss_cnt
);

  localparam int unsigned SW = cw(LOCK_STABLE_CYC);
  localparam int unsigned TW = cw(LOCK_TIMEOUT_CYC);
  localparam int unsigned PW = cw(RST_PULSE_CYC);
  localparam int unsigned GW = cw(STAGGER_CYC);
  localparam int unsigned RW = cw(MAX_RETRY);

  localparam logic [SW-1:0] S_LAST = SW'(LOCK_STABLE_CYC - 1);
  localparam logic [TW-1:0] T_LAST = TW'(LOCK_TIMEOUT_CYC - 1);
  localparam logic [PW-1:0] P_LAST = PW'(RST_PULSE_CYC - 1);
  localparam logic [GW-1:0] G_LAST = GW'(STAGGER_CYC - 1);
  localparam logic [RW-1:0] R_LAST = RW'(MAX_RETRY - 1);

  logic            lock_s;
  adda_seq_state_t state;
  adda_seq_state_t nxt;
  logic [SW-1:0]   scnt;
  logic [TW-1:0]   tcnt;
  logic [PW-1:0]   pcnt;
  logic [GW-1:0]   gcnt;
  logic [RW-1:0]   rcnt;

  adda_sync_2ff u_sync (
    .clk   (clk),
    .rst_n (rst_n),
    .d     (pll_lock),
    .q     (lock_s)
  );

  always_comb begin
    nxt = state;
    unique case (state)
      PLL_RST:
        if (pll_rst_req && pcnt == P_LAST) nxt = WAIT_LOCK;
      WAIT_LOCK:
        if (lock_s) nxt = STABLE;
        else if (tcnt == T_LAST)
          nxt = (rcnt == R_LAST) ? FAULT : PLL_RST;
      STABLE:
        if (!lock_s) nxt = WAIT_LOCK;
        else if (scnt == S_LAST) nxt = REL_ADC;
      REL_ADC:
        if (!lock_s) nxt = PLL_RST;
        else if (gcnt == G_LAST) nxt = RUN;
      RUN:
        if (!lock_s) nxt = PLL_RST;
      FAULT:
        if (retry_i) nxt = PLL_RST;
      default:
        nxt = PLL_RST;
    endcase
  end

  wire stay = (nxt == state);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state         <= PLL_RST;
      scnt          <= '0;
      tcnt          <= '0;
      pcnt          <= '0;
      gcnt          <= '0;
      rcnt          <= '0;
      pll_rst_req   <= 1'b0;
      adc_rst_n     <= 1'b0;
      dac_rst_n     <= 1'b0;
      ready         <= 1'b0;
      fault         <= 1'b0;
      lock_loss_cnt <= '0;
    end else begin
      state       <= nxt;
      pll_rst_req <= (nxt == PLL_RST);
      adc_rst_n   <= (nxt == REL_ADC) || (nxt == RUN);
      dac_rst_n   <= (nxt == RUN);
      ready       <= (nxt == RUN);
      fault       <= (nxt == FAULT);

      // pulse count only runs once the request is visible,
      // so the post-reset pulse is as wide as a re-entry pulse
      if (state != PLL_RST || !stay) pcnt <= '0;
      else if (pll_rst_req && pcnt != P_LAST) pcnt <= pcnt + 1'b1;

      if (state != WAIT_LOCK || !stay) tcnt <= '0;
      else if (tcnt != T_LAST) tcnt <= tcnt + 1'b1;

      // entry cycle already saw lock_s high
      if (nxt != STABLE) scnt <= '0;
      else if (state != STABLE) scnt <= SW'(1);
      else if (scnt != S_LAST) scnt <= scnt + 1'b1;

      if (state != REL_ADC || !stay) gcnt <= '0;
      else if (gcnt != G_LAST) gcnt <= gcnt + 1'b1;

      if (nxt == RUN || (state == FAULT && retry_i)) rcnt <= '0;
      else if (state == WAIT_LOCK && nxt == PLL_RST) rcnt <= rcnt + 1'b1;

      if (state == RUN && !lock_s && lock_loss_cnt != 8'hFF)
        lock_loss_cnt <= lock_loss_cnt + 8'd1;
    end
  end

endmodule

// File: tb/tb_adda_clk_rst_seq.sv
// Bench for adda_clk_rst_seq: timestamp-based reference model
// checked every cycle, plus hand-computed event times.
module tb_adda_clk_rst_seq;

  localparam int LS = 16;
  localparam int LT = 64;
  localparam int RP = 4;
  localparam int SG = 3;
  localparam int MR = 2;

  localparam int M_PULSE = 0;
  localparam int M_WAIT  = 1;
  localparam int M_STAB  = 2;
  localparam int M_STAG  = 3;
  localparam int M_RUN   = 4;
  localparam int M_FAULT = 5;

  logic       clk = 1'b0;
  logic       rst_n = 1'b1;
  logic       pll_lock = 1'b0;
  logic       retry_i = 1'b0;
  logic       pll_rst_req;
  logic       adc_rst_n;
  logic       dac_rst_n;
  logic       ready;
  logic       fault;
  logic [7:0] lock_loss_cnt;

  int nchk = 0;
  int npass = 0;

  int cyc = 0;
  int mode = M_PULSE;
  int t_ent = 1;
  int retries = 0;
  int losses = 0;
  logic h0 = 1'b0;
  logic h1 = 1'b0;
  logic [12:0] exp_out = '0;
  logic [12:0] dut_out;

  int adc_rise = -1;
  int dac_rise = -1;
  int rdy_rise = -1;
  int req_rise = -1;
  int flt_rise = -1;
  int req_len = 0;
  int req_run = 0;
  logic [4:0] prv = '0;

  always #5 clk = ~clk;

  adda_clk_rst_seq #(
    .LOCK_STABLE_CYC  (LS),
    .LOCK_TIMEOUT_CYC (LT),
    .RST_PULSE_CYC    (RP),
    .STAGGER_CYC      (SG),
    .MAX_RETRY        (MR)
  ) dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .pll_lock      (pll_lock),
    .retry_i       (retry_i),
    .pll_rst_req   (pll_rst_req),
    .adc_rst_n     (adc_rst_n),
    .dac_rst_n     (dac_rst_n),
    .ready         (ready),
    .fault         (fault),
    .lock_loss_cnt (lock_loss_cnt)
  );

  assign dut_out = {pll_rst_req, adc_rst_n, dac_rst_n,
                    ready, fault, lock_loss_cnt};

  // reference model: each phase is a start timestamp plus a duration
  always @(posedge clk or negedge rst_n) begin : model
    int m, t, r, l, c;
    logic ls;
    if (!rst_n) begin
      cyc     <= 0;
      mode    <= M_PULSE;
      t_ent   <= 1;
      retries <= 0;
      losses  <= 0;
      h0      <= 1'b0;
      h1      <= 1'b0;
      exp_out <= '0;
    end else begin
      c  = cyc + 1;
      m  = mode;
      t  = t_ent;
      r  = retries;
      l  = losses;
      ls = h1;
      case (mode)
        M_PULSE:
          if (c - t_ent == RP) begin m = M_WAIT; t = c; end
        M_WAIT:
          if (ls) begin
            m = M_STAB; t = c;
          end else if (c - t_ent == LT) begin
            r = r + 1;
            m = (r >= MR) ? M_FAULT : M_PULSE;
            t = c;
          end
        M_STAB:
          if (!ls) begin
            m = M_WAIT; t = c;
          end else if (c - t_ent == LS - 1) begin
            m = M_STAG; t = c;
          end
        M_STAG:
          if (!ls) begin
            m = M_PULSE; t = c;
          end else if (c - t_ent == SG) begin
            m = M_RUN; t = c; r = 0;
          end
        M_RUN:
          if (!ls) begin
            m = M_PULSE; t = c;
            l = (l >= 255) ? 255 : l + 1;
          end
        M_FAULT:
          if (retry_i) begin m = M_PULSE; t = c; r = 0; end
        default: ;
      endcase
      cyc     <= c;
      mode    <= m;
      t_ent   <= t;
      retries <= r;
      losses  <= l;
      h0      <= pll_lock;
      h1      <= h0;
      exp_out <= {m == M_PULSE, m == M_STAG || m == M_RUN,
                  m == M_RUN, m == M_RUN, m == M_FAULT, 8'(l)};
    end
  end

  task automatic chk(input string nm, input longint act,
                     input longint exp);
    nchk++;
    if (act == exp) npass++;
    else $display("FAIL %s at cyc %0d: got %0h expected %0h",
                  nm, cyc, act, exp);
  endtask

  task automatic at_cyc(input int k);
    while (cyc < k) @(negedge clk);
  endtask

  task automatic wait_ready(input int budget);
    int n = 0;
    while (!ready && n < budget) begin
      @(negedge clk);
      n++;
    end
    if (!ready) begin
      nchk++;
      $display("FAIL wait_ready: ready=0 after %0d cycles, required 1",
               budget);
    end
  endtask

  task automatic reset_seq(input logic lk);
    @(negedge clk);
    #2;
    rst_n    = 1'b0;
    pll_lock = lk;
    retry_i  = 1'b0;
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  // per-cycle comparison and edge-time monitor
  initial forever begin
    @(negedge clk);
    chk("outputs", dut_out, exp_out);
    if (!rst_n) begin
      adc_rise = -1; dac_rise = -1; rdy_rise = -1;
      req_rise = -1; flt_rise = -1;
      req_len = 0; req_run = 0; prv = '0;
    end else begin
      if (pll_rst_req && !prv[4]) begin
        req_rise = cyc; req_run = 0;
      end
      if (pll_rst_req) req_run++;
      if (!pll_rst_req && prv[4]) req_len = req_run;
      if (adc_rst_n && !prv[3]) adc_rise = cyc;
      if (dac_rst_n && !prv[2]) dac_rise = cyc;
      if (ready && !prv[1]) rdy_rise = cyc;
      if (fault && !prv[0]) flt_rise = cyc;
      prv = {pll_rst_req, adc_rst_n, dac_rst_n, ready, fault};
    end
  end

  initial begin
    #1 rst_n = 1'b0;
    #1 chk("reset_vals", dut_out, 0);
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;

    // nominal bring-up, then lock loss in RUN
    at_cyc(10); pll_lock = 1'b1;
    at_cyc(35); retry_i = 1'b1;
    at_cyc(36); retry_i = 1'b0;
    at_cyc(40);
    chk("nom_req_rise", req_rise, 1);
    chk("nom_req_len", req_len, 4);
    chk("nom_adc_rise", adc_rise, 28);
    chk("nom_dac_rise", dac_rise, 31);
    chk("nom_rdy_rise", rdy_rise, 31);
    pll_lock = 1'b0;
    at_cyc(42); chk("loss_rdy_pre", ready, 1);
    at_cyc(43);
    chk("loss_req", pll_rst_req, 1);
    chk("loss_adc", adc_rst_n, 0);
    chk("loss_rdy", ready, 0);
    chk("loss_cnt", lock_loss_cnt, 1);
    at_cyc(45); pll_lock = 1'b1;

    // async reset while re-qualifying lock
    at_cyc(55);
    chk("pre_async_cnt", lock_loss_cnt, 1);
    #2 rst_n = 1'b0;
    #1 chk("async_vals", dut_out, 0);
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    at_cyc(30);
    chk("rst_req_rise", req_rise, 1);
    chk("rst_req_len", req_len, 4);
    chk("rst_adc_rise", adc_rise, 21);
    chk("rst_rdy_rise", rdy_rise, 24);

    // lock glitch in STABLE, then lock loss in REL_ADC
    reset_seq(1'b0);
    at_cyc(10); pll_lock = 1'b1;
    at_cyc(20); pll_lock = 1'b0;
    at_cyc(21); pll_lock = 1'b1;
    at_cyc(37); pll_lock = 1'b0;
    at_cyc(45);
    chk("gl_adc_rise", adc_rise, 39);
    chk("gl_dac_rise", dac_rise, -1);
    chk("gl_req_rise", req_rise, 40);
    chk("gl_loss_cnt", lock_loss_cnt, 0);

    // lock timeout, retries exhausted, manual retry
    reset_seq(1'b0);
    at_cyc(140);
    chk("to_req_rise", req_rise, 69);
    chk("to_flt_rise", flt_rise, 137);
    chk("to_fault", fault, 1);
    chk("to_adc", adc_rst_n, 0);
    retry_i = 1'b1;
    at_cyc(141);
    retry_i = 1'b0;
    chk("rt_req", pll_rst_req, 1);
    chk("rt_fault", fault, 0);
    at_cyc(146);
    chk("rt_req_len", req_len, 4);

    // lock loss counter saturation
    reset_seq(1'b0);
    for (int i = 0; i < 260; i++) begin
      pll_lock = 1'b1;
      wait_ready(200);
      pll_lock = 1'b0;
      repeat (4) @(negedge clk);
    end
    chk("sat_cnt", lock_loss_cnt, 255);

    $display("%0d/%0d checks passed", npass, nchk);
    $finish;
  end

endmodule
